// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer between pipeline stages.
// MAIN drives the downstream port directly and SKID catches the one payload
// that can arrive while downstream is stalled. up_ready depends only on state,
// so the ready path is cut and never comes combinationally from dn_ready.
module pipe_skid_stage #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 3,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  input  logic [CTRL_W-1:0] up_ctrl,
  input  logic [RD_W-1:0]   up_rd,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [CTRL_W-1:0] dn_ctrl,
  output logic [RD_W-1:0]   dn_rd,
  output logic [1:0]        occ,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;
  } pay_t;

  state_e      state_q, state_d;
  pay_t        main_q, main_d;
  pay_t        skid_q, skid_d;
  pay_t        up_pay;
  logic        up_ready_q, up_ready_d;
  logic        dn_valid_q, dn_valid_d;
  logic [1:0]  occ_q, occ_d;
  logic [15:0] stall_q, stall_d;
  logic        up_fire, dn_fire;

  assign up_pay  = '{data: up_data, ctrl: up_ctrl, rd: up_rd};
  assign up_fire = up_valid & up_ready_q;
  assign dn_fire = dn_valid_q & dn_ready;

  // Next-state / payload steering; flush forces EMPTY but leaves payload regs alone.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (up_fire) begin
          main_d  = up_pay;
          state_d = ONE;
        end
      end
      ONE: begin
        unique case ({up_fire, dn_fire})
          2'b11: main_d = up_pay;
          2'b01: state_d = EMPTY;
          2'b10: begin
            skid_d  = up_pay;
            state_d = FULL;
          end
          default: ;
        endcase
      end
      FULL: begin
        if (dn_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    up_ready_d = (state_d != FULL);
    dn_valid_d = (state_d != EMPTY);
    occ_d      = (state_d == FULL) ? 2'd2 : ((state_d == ONE) ? 2'd1 : 2'd0);
  end

  // Stall counter counts presented-but-refused cycles and sticks at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (dn_valid_q && !dn_ready && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  // State, payload and registered status outputs; reset beats flush and handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      up_ready_q <= 1'b1;
      dn_valid_q <= 1'b0;
      occ_q      <= 2'd0;
      stall_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      up_ready_q <= up_ready_d;
      dn_valid_q <= dn_valid_d;
      occ_q      <= occ_d;
      stall_q    <= stall_d;
    end
  end

  assign up_ready  = up_ready_q;
  assign dn_valid  = dn_valid_q;
  assign dn_data   = main_q.data;
  assign dn_rd     = main_q.rd;
  // A bubble must never carry a write enable downstream.
  assign dn_ctrl   = main_q.ctrl & {CTRL_W{dn_valid_q}};
  assign occ       = occ_q;
  assign stall_cnt = stall_q;

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 128, sets the width of the datapath payload (four 32-bit words).
REQ-002 Parameter CTRL_W, default 3, sets the width of the control bundle (MEM_wen, WB_sel, Reg_WB).
REQ-003 Parameter RD_W, default 5, sets the width of the destination register index.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  discards all held entries at the next edge.
REQ-007 up_valid  input  1  upstream offers a payload this cycle.
REQ-008 up_ready  output  1  stage can accept a payload this cycle.
REQ-009 up_data / up_ctrl / up_rd  input  DATA_W / CTRL_W / RD_W  upstream payload.
REQ-010 dn_valid  output  1  stage presents a valid payload.
REQ-011 dn_ready  input  1  downstream consumes the presented payload this cycle.
REQ-012 dn_data / dn_ctrl / dn_rd  output  DATA_W / CTRL_W / RD_W  presented payload.
REQ-013 occ  output  2  number of held entries (0..2).
REQ-014 stall_cnt  output  16  saturating count of cycles with dn_valid=1 and dn_ready=0.

Function
REQ-015 The stage SHALL define up_fire = up_valid & up_ready and dn_fire = dn_valid & dn_ready.
REQ-016 The stage SHALL hold two entries, MAIN (presented downstream) and SKID, giving states EMPTY, ONE and FULL.
REQ-017 up_ready SHALL be 1 exactly when the state is not FULL, and SHALL have no combinational path from dn_ready.
REQ-018 dn_valid SHALL be 1 exactly when the state is ONE or FULL, and dn_data/dn_rd SHALL come directly from MAIN registers.
REQ-019 dn_ctrl SHALL equal MAIN ctrl ANDed with dn_valid, so a bubble never asserts a write enable.
REQ-020 In EMPTY, up_fire SHALL load MAIN and transition to ONE.
REQ-021 In ONE, up_fire together with dn_fire SHALL load MAIN from upstream and remain in ONE.
REQ-022 In ONE, dn_fire alone SHALL transition to EMPTY.
REQ-023 In ONE, up_fire alone SHALL load SKID and transition to FULL.
REQ-024 In ONE, a cycle with neither fire SHALL hold all registers.
REQ-025 In FULL, dn_fire SHALL copy SKID into MAIN and transition to ONE; otherwise all registers SHALL hold.
REQ-026 Latency from up_fire to the payload on dn_* SHALL be 1 cycle when the stage is EMPTY, or when in ONE with dn_fire.
REQ-027 Sustained throughput SHALL be one transfer per cycle while dn_ready=1.
REQ-028 Payload order SHALL be preserved, with no loss or duplication.
REQ-029 occ SHALL be 0/1/2 for EMPTY/ONE/FULL respectively.
REQ-030 On flush=1, the next state SHALL be EMPTY regardless of up_fire/dn_fire in that cycle, and any same-cycle upstream payload is discarded.
REQ-031 On flush, payload registers SHALL hold their values (don't-care while invalid), and dn_ctrl SHALL read 0 per REQ-019.
REQ-032 stall_cnt SHALL increment by 1 on every cycle with dn_valid=1 and dn_ready=0.
REQ-033 stall_cnt SHALL saturate at 16'hFFFF and SHALL be unaffected by flush.
REQ-034 reset SHALL take priority over flush and all handshakes.

Reset
REQ-035 On a reset edge, the state SHALL go to EMPTY and all MAIN/SKID data, ctrl and rd registers SHALL be 0.
REQ-036 On a reset edge, stall_cnt SHALL be 0.
REQ-037 After reset, outputs SHALL be dn_valid=0, dn_ctrl=0, dn_data=0, dn_rd=0, occ=0 and up_ready=1.
REQ-038 up_valid asserted during a reset cycle SHALL be ignored.

Verification
REQ-039 Reset, then up_valid=1 with data=32'h0000_00A5 in word 0, rd=5'd7, ctrl=3'b111 and dn_ready=1 -> next cycle dn_valid=1, rd=7, ctrl=3'b111, occ=1.
REQ-040 With dn_ready=0, push A then B -> occ=2 and up_ready=0; raise dn_ready -> A then B are presented on consecutive cycles, and stall_cnt equals the number of held cycles.
REQ-041 Stream 100 random payloads with random dn_ready -> output sequence identical to input sequence, and up_ready never falls while occ<2.
REQ-042 In FULL, assert flush with up_valid=1 -> next cycle occ=0, dn_valid=0, dn_ctrl=0, and the flushed payload never appears.
REQ-043 Hold dn_valid=1, dn_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF and stays there.
REQ-044 Assert reset while FULL with stall_cnt nonzero -> next cycle all outputs match REQ-037 and stall_cnt=0.
